// File: rtl/l1c_tag_dir.sv
// N-way set-associative tag directory for the L1 data cache, with 1-cycle lookups, fills, invalidates and a self-clearing sweep.
// Define L1C_TAG_DIR_PLRU_EN to use tree pseudo-LRU replacement instead of per-set round-robin.
module l1c_tag_dir #(
    parameter int ADDR_WIDTH  = 48,
    parameter int SET_NUM     = 512,
    parameter int WAY_NUM     = 4,
    parameter int OFFSET      = 6,
    localparam int INDEX_WIDTH = $clog2(SET_NUM),
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET,
    localparam int WAY_WIDTH   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  init_done_o,
    input  logic                  flush_req_i,
    input  logic                  lkp_req_i,
    input  logic [ADDR_WIDTH-1:0] lkp_addr_i,
    output logic                  lkp_gnt_o,
    output logic                  lkp_vld_o,
    output logic                  lkp_hit_o,
    output logic [WAY_WIDTH-1:0]  lkp_way_o,
    output logic                  lkp_victim_vld_o,
    output logic [TAG_WIDTH-1:0]  lkp_victim_tag_o,
    input  logic                  fill_req_i,
    input  logic [ADDR_WIDTH-1:0] fill_addr_i,
    input  logic [WAY_WIDTH-1:0]  fill_way_i,
    input  logic                  inv_req_i,
    input  logic [ADDR_WIDTH-1:0] inv_addr_i
);
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] sweep_idx;

    logic [WAY_NUM-1:0]     valid [SET_NUM];
    logic [TAG_WIDTH-1:0]   tags  [SET_NUM][WAY_NUM];

    logic [INDEX_WIDTH-1:0] lkp_idx, fill_idx, inv_idx;
    logic [TAG_WIDTH-1:0]   lkp_tag, fill_tag, inv_tag;

    logic                   hit, free_found;
    logic [WAY_WIDTH-1:0]   hit_way, free_way, repl_way, res_way;
    logic [TAG_WIDTH-1:0]   res_victim_tag;
    logic                   unused_bits;

    assign lkp_idx  = lkp_addr_i[OFFSET +: INDEX_WIDTH];
    assign fill_idx = fill_addr_i[OFFSET +: INDEX_WIDTH];
    assign inv_idx  = inv_addr_i[OFFSET +: INDEX_WIDTH];
    assign lkp_tag  = lkp_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign fill_tag = fill_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign inv_tag  = inv_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];

    assign unused_bits = ^{lkp_addr_i[OFFSET-1:0], fill_addr_i[OFFSET-1:0], inv_addr_i[OFFSET-1:0]};

    assign init_done_o = (state == ST_READY);
    assign lkp_gnt_o   = (state == ST_READY) & lkp_req_i & ~fill_req_i & ~inv_req_i;

`ifdef L1C_TAG_DIR_PLRU_EN
    localparam int PLRU_W = (WAY_NUM > 1) ? WAY_NUM - 1 : 1;

    logic [PLRU_W-1:0] plru [SET_NUM];

    // Heap-ordered tree: node n has children 2n+1 (bit 0, left) and 2n+2 (bit 1, right).
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_WIDTH-1:0] way);
        logic [PLRU_W-1:0] result;
        int node;
        result = bits;
        node   = 0;
        if (WAY_NUM > 1) begin
            for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
                for (int n = 0; n < PLRU_W; n++)
                    if (n == node) result[n] = ~way[WAY_WIDTH-1-lvl];
                node = 2 * node + 1 + int'(way[WAY_WIDTH-1-lvl]);
            end
        end
        return result;
    endfunction

    function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_WIDTH-1:0] way;
        logic b;
        int node;
        way  = '0;
        node = 0;
        if (WAY_NUM > 1) begin
            for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
                b = 1'b0;
                for (int n = 0; n < PLRU_W; n++)
                    if (n == node) b = bits[n];
                way[WAY_WIDTH-1-lvl] = b;
                node = 2 * node + 1 + int'(b);
            end
        end
        return way;
    endfunction

    assign repl_way = plru_victim(plru[lkp_idx]);

    always_ff @(posedge clk_i) begin
        if (state == ST_INIT)
            plru[sweep_idx] <= '0;
        else if (fill_req_i)
            plru[fill_idx] <= plru_touch(plru[fill_idx], fill_way_i);
        else if (lkp_gnt_o && hit)
            plru[lkp_idx] <= plru_touch(plru[lkp_idx], hit_way);
    end
`else
    logic [WAY_WIDTH-1:0] rr_ptr [SET_NUM];

    assign repl_way = rr_ptr[lkp_idx];

    always_ff @(posedge clk_i) begin
        if (state == ST_INIT)
            rr_ptr[sweep_idx] <= '0;
        else if (fill_req_i)
            rr_ptr[fill_idx] <= (WAY_NUM > 1) ? fill_way_i + WAY_WIDTH'(1) : '0;
    end
`endif

    // Downward scans leave the lowest-index match / free way as the winner.
    always_comb begin
        hit            = 1'b0;
        hit_way        = '0;
        free_found     = 1'b0;
        free_way       = '0;
        res_victim_tag = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (valid[lkp_idx][w] && tags[lkp_idx][w] == lkp_tag) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
            if (!valid[lkp_idx][w]) begin
                free_found = 1'b1;
                free_way   = WAY_WIDTH'(w);
            end
        end
        res_way = hit ? hit_way : (free_found ? free_way : repl_way);
        for (int w = 0; w < WAY_NUM; w++)
            if (WAY_WIDTH'(w) == res_way) res_victim_tag = tags[lkp_idx][w];
    end

    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            valid[sweep_idx] <= '0;
        end else if (fill_req_i) begin
            valid[fill_idx][fill_way_i] <= 1'b1;
            tags[fill_idx][fill_way_i]  <= fill_tag;
        end else if (inv_req_i) begin
            for (int w = 0; w < WAY_NUM; w++)
                if (valid[inv_idx][w] && tags[inv_idx][w] == inv_tag)
                    valid[inv_idx][w] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == INDEX_WIDTH'(SET_NUM - 1)) state <= ST_READY;
                end
                default: begin
                    if (flush_req_i) begin
                        state     <= ST_INIT;
                        sweep_idx <= '0;
                    end
                end
            endcase
        end
    end

    // Result fields hold between lookups; only the valid strobe is a single-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lkp_vld_o        <= 1'b0;
            lkp_hit_o        <= 1'b0;
            lkp_way_o        <= '0;
            lkp_victim_vld_o <= 1'b0;
            lkp_victim_tag_o <= '0;
        end else begin
            lkp_vld_o <= lkp_gnt_o;
            if (lkp_gnt_o) begin
                lkp_hit_o        <= hit;
                lkp_way_o        <= res_way;
                lkp_victim_vld_o <= ~hit & ~free_found;
                lkp_victim_tag_o <= res_victim_tag;
            end
        end
    end
endmodule

// File: tb/tb_l1c_tag_dir.sv
// Self-checking bench for l1c_tag_dir: directed scenarios plus randomized traffic against an array-based directory model.
module tb_l1c_tag_dir;
    localparam int AW = 48;
    localparam int TW = 33;
    localparam int WW = 2;

    typedef struct packed {
        logic          hit;
        logic [WW-1:0] way;
        logic          vv;
        logic [TW-1:0] vt;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          flush_req = 1'b0;
    logic          lkp_req = 1'b0;
    logic [AW-1:0] lkp_addr = '0;
    logic          lkp_gnt, lkp_vld, lkp_hit, lkp_victim_vld;
    logic [WW-1:0] lkp_way;
    logic [TW-1:0] lkp_victim_tag;
    logic          fill_req = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic [WW-1:0] fill_way = '0;
    logic          inv_req = 1'b0;
    logic [AW-1:0] inv_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference directory: per-set valid/tag per way and the round-robin "next victim" way.
    bit            mv  [512][4];
    logic [TW-1:0] mt  [512][4];
    int            mrr [512];

    l1c_tag_dir dut (
        .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done), .flush_req_i(flush_req),
        .lkp_req_i(lkp_req), .lkp_addr_i(lkp_addr), .lkp_gnt_o(lkp_gnt), .lkp_vld_o(lkp_vld),
        .lkp_hit_o(lkp_hit), .lkp_way_o(lkp_way), .lkp_victim_vld_o(lkp_victim_vld),
        .lkp_victim_tag_o(lkp_victim_tag), .fill_req_i(fill_req), .fill_addr_i(fill_addr),
        .fill_way_i(fill_way), .inv_req_i(inv_req), .inv_addr_i(inv_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [AW-1:0] mk(input int tag, input int set);
        logic [AW-1:0] a;
        a = (AW'(tag) << 15) | (AW'(set) << 6) | AW'($urandom_range(0, 63));
        return a;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 512; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
        end
    endfunction

    function automatic void m_fill(input logic [AW-1:0] a, input int w);
        int s;
        s = int'(a[14:6]);
        mv[s][w] = 1'b1;
        mt[s][w] = a[47:15];
        mrr[s]   = (w + 1) % 4;
    endfunction

    function automatic void m_inv(input logic [AW-1:0] a);
        int s;
        s = int'(a[14:6]);
        for (int w = 0; w < 4; w++)
            if (mv[s][w] && mt[s][w] == a[47:15]) mv[s][w] = 1'b0;
    endfunction

    function automatic res_t m_lookup(input logic [AW-1:0] a);
        res_t r;
        int s;
        s = int'(a[14:6]);
        r = '0;
        for (int w = 0; w < 4; w++)
            if (mv[s][w] && mt[s][w] == a[47:15]) begin
                r.hit = 1'b1;
                r.way = WW'(w);
                return r;
            end
        for (int w = 0; w < 4; w++)
            if (!mv[s][w]) begin
                r.way = WW'(w);
                return r;
            end
        r.way = WW'(mrr[s]);
        r.vv  = 1'b1;
        r.vt  = mt[s][mrr[s]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [AW-1:0] a, input int w);
        fill_req  = 1'b1;
        fill_addr = a;
        fill_way  = WW'(w);
        tick();
        fill_req  = 1'b0;
        m_fill(a, w);
    endtask

    task automatic do_inv(input logic [AW-1:0] a);
        inv_req  = 1'b1;
        inv_addr = a;
        tick();
        inv_req  = 1'b0;
        m_inv(a);
    endtask

    // Drives a single lookup and captures grant, valid strobe and the registered result; victim tag is zeroed when no eviction is reported.
    task automatic do_lookup(input logic [AW-1:0] a, output bit gnt, output bit vld, output res_t r);
        lkp_req  = 1'b1;
        lkp_addr = a;
        #1;
        gnt = lkp_gnt;
        tick();
        vld = lkp_vld;
        r   = {lkp_hit, lkp_way, lkp_victim_vld, lkp_victim_tag};
        if (!r.vv) r.vt = '0;
        lkp_req = 1'b0;
    endtask

    task automatic test_reset();
        int  cycles;
        bit  gnt_early;
        rst_n    = 1'b0;
        lkp_req  = 1'b1;
        lkp_addr = mk(1, 2);
        repeat (3) tick();
        n_tests++;
        if ({init_done, lkp_gnt, lkp_vld, lkp_hit, lkp_way, lkp_victim_vld, lkp_victim_tag} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {init_done, lkp_gnt, lkp_vld, lkp_hit, lkp_way, lkp_victim_vld, lkp_victim_tag});
        end
        rst_n     = 1'b1;
        cycles    = 0;
        gnt_early = 1'b0;
        while (init_done !== 1'b1 && cycles < 600) begin
            if (lkp_gnt !== 1'b0) gnt_early = 1'b1;
            tick();
            cycles++;
        end
        n_tests++;
        if (cycles != 512) begin
            n_fail++;
            $display("[TB] FAIL init_latency got=%0d exp=512", cycles);
        end
        n_tests++;
        if (gnt_early || lkp_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL init_gnt early=%0d gnt_after=%b exp early=0 gnt_after=1", gnt_early, lkp_gnt);
        end
        lkp_req = 1'b0;
        m_clear();
    endtask

    task automatic test_hit_miss();
        bit   g, v;
        res_t got, exp;
        do_fill(48'h1040, 2);
        exp = m_lookup(48'h1040);
        do_lookup(48'h1040, g, v, got);
        n_tests++;
        if (!g || !v || got.hit !== 1'b1 || got.way !== 2'd2 || got !== exp) begin
            n_fail++;
            $display("[TB] FAIL hit_way2 gnt=%b vld=%b got=%h exp=%h", g, v, got, exp);
        end
        tick();
        n_tests++;
        if (lkp_vld !== 1'b0 || lkp_hit !== 1'b1 || lkp_way !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL vld_pulse_hold vld=%b hit=%b way=%0d exp vld=0 hit=1 way=2", lkp_vld, lkp_hit, lkp_way);
        end
        exp = m_lookup(48'h9040);
        do_lookup(48'h9040, g, v, got);
        n_tests++;
        if (!g || !v || got.hit !== 1'b0 || got.way !== 2'd0 || got.vv !== 1'b0 || got !== exp) begin
            n_fail++;
            $display("[TB] FAIL miss_free gnt=%b vld=%b got=%h exp=%h", g, v, got, exp);
        end
    endtask

    task automatic test_round_robin();
        bit   g, v;
        res_t got;
        for (int w = 0; w < 4; w++) do_fill(mk(w + 1, 'h41), w);
        do_lookup(mk(5, 'h41), g, v, got);
        n_tests++;
        if (!v || got !== {1'b0, 2'd0, 1'b1, 33'd1}) begin
            n_fail++;
            $display("[TB] FAIL rr_victim0 got=%h exp=%h", got, {1'b0, 2'd0, 1'b1, 33'd1});
        end
        do_fill(mk(5, 'h41), 0);
        do_lookup(mk(6, 'h41), g, v, got);
        n_tests++;
        if (!v || got !== {1'b0, 2'd1, 1'b1, 33'd2}) begin
            n_fail++;
            $display("[TB] FAIL rr_victim1 got=%h exp=%h", got, {1'b0, 2'd1, 1'b1, 33'd2});
        end
    endtask

    task automatic test_invalidate();
        bit   g, v;
        res_t got;
        for (int w = 0; w < 4; w++) do_fill(mk(w + 1, 'h42), w);
        do_inv(mk(3, 'h42));
        do_lookup(mk(3, 'h42), g, v, got);
        n_tests++;
        if (!v || got.hit !== 1'b0 || got.way !== 2'd2 || got.vv !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL inv_miss got=%h exp hit=0 way=2 vv=0", got);
        end
        do_inv(mk(99, 'h42));
        do_lookup(mk(4, 'h42), g, v, got);
        n_tests++;
        if (!v || got.hit !== 1'b1 || got.way !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL inv_nomatch got=%h exp hit=1 way=3", got);
        end
    endtask

    task automatic test_priority();
        bit   g;
        logic [AW-1:0] a;
        a         = mk(7, 'h43);
        fill_req  = 1'b1;
        fill_addr = a;
        fill_way  = 2'd1;
        lkp_req   = 1'b1;
        lkp_addr  = a;
        #1;
        g = lkp_gnt;
        n_tests++;
        if (g !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fill_blocks_lkp gnt=%b exp=0", g);
        end
        tick();
        fill_req = 1'b0;
        m_fill(a, 1);
        #1;
        g = lkp_gnt;
        tick();
        n_tests++;
        if (g !== 1'b1 || lkp_vld !== 1'b1 || lkp_hit !== 1'b1 || lkp_way !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL lkp_after_fill gnt=%b vld=%b hit=%b way=%0d exp 1 1 1 1", g, lkp_vld, lkp_hit, lkp_way);
        end
        inv_req  = 1'b1;
        inv_addr = mk(50, 'h43);
        #1;
        g = lkp_gnt;
        tick();
        inv_req = 1'b0;
        lkp_req = 1'b0;
        n_tests++;
        if (g !== 1'b0 || lkp_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL inv_blocks_lkp gnt=%b vld=%b exp 0 0", g, lkp_vld);
        end
    endtask

    task automatic test_replacement();
        bit   g, v;
        res_t got;
        logic [WW-1:0] want;
        for (int w = 0; w < 4; w++) do_fill(mk(w + 10, 'h80), w);
        do_lookup(mk(10, 'h80), g, v, got);
        do_lookup(mk(12, 'h80), g, v, got);
        n_tests++;
        if (!v || got.hit !== 1'b1 || got.way !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL repl_hit2 got=%h exp hit=1 way=2", got);
        end
`ifdef L1C_TAG_DIR_PLRU_EN
        want = 2'd1;
`else
        want = 2'd0;
`endif
        do_lookup(mk(20, 'h80), g, v, got);
        n_tests++;
        if (!v || got.hit !== 1'b0 || got.vv !== 1'b1 || got.way !== want || got.vt !== 33'(10 + int'(want))) begin
            n_fail++;
            $display("[TB] FAIL repl_victim got=%h exp way=%0d vv=1 vt=%0d", got, want, 10 + int'(want));
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        logic [AW-1:0] a;
        bit g;
        lkp_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a        = mk($urandom_range(1, 7), 'h42);
            exp      = m_lookup(a);
            lkp_addr = a;
            #1;
            g = lkp_gnt;
            tick();
            got = {lkp_hit, lkp_way, lkp_victim_vld, lkp_victim_tag};
            if (!got.vv) got.vt = '0;
`ifdef L1C_TAG_DIR_PLRU_EN
            if (exp.vv) begin got.way = '0; got.vt = '0; exp.way = '0; exp.vt = '0; end
`endif
            n_tests++;
            if (g !== 1'b1 || lkp_vld !== 1'b1 || got !== exp) begin
                n_fail++;
                $display("[TB] FAIL b2b_%0d gnt=%b vld=%b got=%h exp=%h", i, g, lkp_vld, got, exp);
            end
        end
        lkp_req = 1'b0;
        tick();
        n_tests++;
        if (lkp_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_vld_drop got=%b exp=0", lkp_vld);
        end
    endtask

    task automatic test_random();
        int op, s, t, w;
        bit dup, g, v;
        logic [AW-1:0] a;
        res_t got, exp;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 2);
            s  = 'h10 + $urandom_range(0, 2);
            t  = $urandom_range(0, 5);
            w  = $urandom_range(0, 3);
            a  = mk(t, s);
            if (op == 0) begin
                dup = 1'b0;
                for (int k = 0; k < 4; k++)
                    if (k != w && mv[s][k] && mt[s][k] == a[47:15]) dup = 1'b1;
                if (!dup) do_fill(a, w);
            end else if (op == 1) begin
                do_inv(a);
            end else begin
                exp = m_lookup(a);
                do_lookup(a, g, v, got);
`ifdef L1C_TAG_DIR_PLRU_EN
                if (exp.vv) begin got.way = '0; got.vt = '0; exp.way = '0; exp.vt = '0; end
`endif
                n_tests++;
                if (!g || !v || got !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL rand_lkp_%0d addr=%h gnt=%b vld=%b got=%h exp=%h", i, a, g, v, got, exp);
                end
            end
        end
    endtask

    task automatic test_flush();
        int   cycles;
        bit   g, v;
        res_t got, exp;
        exp       = m_lookup(mk(11, 'h80));
        flush_req = 1'b1;
        lkp_req   = 1'b1;
        lkp_addr  = mk(11, 'h80);
        #1;
        g = lkp_gnt;
        tick();
        flush_req = 1'b0;
        lkp_req   = 1'b0;
        got = {lkp_hit, lkp_way, lkp_victim_vld, lkp_victim_tag};
        if (!got.vv) got.vt = '0;
        n_tests++;
        if (g !== 1'b1 || lkp_vld !== 1'b1 || got !== exp || init_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_inflight gnt=%b vld=%b done=%b got=%h exp=%h", g, lkp_vld, init_done, got, exp);
        end
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 600) begin
            tick();
            cycles++;
        end
        n_tests++;
        if (cycles != 512) begin
            n_fail++;
            $display("[TB] FAIL flush_latency got=%0d exp=512", cycles);
        end
        m_clear();
        for (int i = 0; i < 4; i++) begin
            do_lookup(mk(10 + i, 'h80), g, v, got);
            n_tests++;
            if (!v || got.hit !== 1'b0 || got.vv !== 1'b0 || got.way !== 2'd0) begin
                n_fail++;
                $display("[TB] FAIL flush_cleared_%0d got=%h exp hit=0 vv=0 way=0", i, got);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_miss();
`ifndef L1C_TAG_DIR_PLRU_EN
        test_round_robin();
`endif
        test_invalidate();
        test_priority();
        test_replacement();
        test_back_to_back();
        test_random();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
